// File: rtl/acc_stack_if.sv
// acc_stack_if: operation/source bus and status outputs of the accumulator stack.
interface acc_stack_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned SELW = $clog2(NSRC);
  localparam int unsigned DCW  = $clog2(DEPTH + 1);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [SELW-1:0]       src_sel;
  logic [2:0]            op;
  logic                  err_clr;
  logic [WIDTH-1:0]      acc_out;
  logic [DCW-1:0]        depth_cnt;
  logic                  full;
  logic                  empty;
  logic                  carry;
  logic                  err;

  modport master (
    output src_data, src_sel, op, err_clr,
    input  acc_out, depth_cnt, full, empty, carry, err
  );

  modport slave (
    input  src_data, src_sel, op, err_clr,
    output acc_out, depth_cnt, full, empty, carry, err
  );
endinterface

// File: rtl/acc_stack.sv
// acc_stack: accumulator with a LIFO save stack and sticky error flag.
// Optional ADD operation is compiled in with macro ACC_STACK_ADD_EN.
module acc_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  acc_stack_if.slave  bus
);
  localparam int unsigned SELW = $clog2(NSRC);
  localparam int unsigned DCW  = $clog2(DEPTH + 1);
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_PUSH = 3'b010,
    OP_POP  = 3'b011,
    OP_ADD  = 3'b100
  } op_e;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [DCW-1:0]   depth_q, depth_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             is_full;
  logic             is_empty;
  logic             err_set;
  logic             push_we;
  logic [PTRW-1:0]  push_idx;
  logic [PTRW-1:0]  pop_idx;

  // Select the addressed source channel; out-of-range selects are flagged
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      if (bus.src_sel == SELW'(k)) sel_data = bus.src_data[k*WIDTH +: WIDTH];
    end
    sel_ok   = (32'(bus.src_sel) < NSRC);
    is_full  = (depth_q == DCW'(DEPTH));
    is_empty = (depth_q == '0);
    push_idx = PTRW'(depth_q);
    pop_idx  = PTRW'(depth_q - DCW'(1));
  end

  // Operation decode: next accumulator, depth, carry and error state
  always_comb begin
    acc_d   = acc_q;
    depth_d = depth_q;
    carry_d = carry_q;
    err_set = 1'b0;
    push_we = 1'b0;

    case (bus.op)
      OP_LOAD: begin
        if (!sel_ok) err_set = 1'b1;
        else         acc_d   = sel_data;
      end
      OP_PUSH: begin
        if (!sel_ok || is_full) begin
          err_set = 1'b1;
        end else begin
          push_we = 1'b1;
          acc_d   = sel_data;
          depth_d = depth_q + DCW'(1);
        end
      end
      OP_POP: begin
        if (is_empty) begin
          err_set = 1'b1;
        end else begin
          acc_d   = stack_q[pop_idx];
          depth_d = depth_q - DCW'(1);
        end
      end
`ifdef ACC_STACK_ADD_EN
      OP_ADD: begin
        if (!sel_ok) err_set = 1'b1;
        else         {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, sel_data};
      end
`endif
      default: ;
    endcase

`ifndef ACC_STACK_ADD_EN
    carry_d = 1'b0;
`endif

    // A new error wins over a simultaneous clear
    if (err_set)          err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
    else                  err_d = err_q;

    full_d  = (depth_d == DCW'(DEPTH));
    empty_d = (depth_d == '0);
  end

  // Control and status registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      depth_q <= depth_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; only depth_q qualifies its contents
  always_ff @(posedge clk) begin
    if (push_we && !reset) stack_q[push_idx] <= acc_q;
  end

  assign bus.acc_out   = acc_q;
  assign bus.depth_cnt = depth_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.carry     = carry_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_acc_stack.sv
// tb_acc_stack: directed and randomized checks of acc_stack against a queue-based model.
module tb_acc_stack;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned NSRC  = 4;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;

  acc_stack_if #(.WIDTH(WIDTH), .NSRC(NSRC), .DEPTH(DEPTH)) bus ();

  acc_stack #(.WIDTH(WIDTH), .NSRC(NSRC), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_acc;
  logic [7:0] m_stk [$];
  logic       m_err;
  logic       m_carry;
  logic [7:0] src [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_src(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
    src[0] = s0; src[1] = s1; src[2] = s2; src[3] = s3;
    bus.src_data = {s3, s2, s1, s0};
  endtask

  task automatic model_reset();
    m_acc   = 8'h00;
    m_stk.delete();
    m_err   = 1'b0;
    m_carry = 1'b0;
  endtask

  // Present one op for one edge and advance the model by the same op
  task automatic drive(input logic [2:0] op, input logic [1:0] sel, input logic clr);
    logic new_err;
`ifdef ACC_STACK_ADD_EN
    logic [8:0] sum;
`endif
    bus.op      = op;
    bus.src_sel = sel;
    bus.err_clr = clr;
    new_err = 1'b0;
    case (op)
      3'd1: m_acc = src[sel];
      3'd2: begin
        if (m_stk.size() == int'(DEPTH)) new_err = 1'b1;
        else begin
          m_stk.push_back(m_acc);
          m_acc = src[sel];
        end
      end
      3'd3: begin
        if (m_stk.size() == 0) new_err = 1'b1;
        else m_acc = m_stk.pop_back();
      end
      3'd4: begin
`ifdef ACC_STACK_ADD_EN
        sum     = {1'b0, m_acc} + {1'b0, src[sel]};
        m_acc   = sum[7:0];
        m_carry = sum[8];
`endif
      end
      default: ;
    endcase
    if (new_err)  m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    @(posedge clk);
    #1;
    bus.op      = 3'd0;
    bus.err_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.op = 3'd0; bus.src_sel = 2'd0; bus.err_clr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.op = 3'd0; bus.src_sel = 2'd0; bus.err_clr = 1'b0;
    set_src(8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.acc_out !== 8'h00) begin n_bad++; $display("FAIL reset_acc: got %h want 00", bus.acc_out); end
    n_cmp++; if (bus.depth_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_depth: got %0d want 0", bus.depth_cnt); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.carry !== 1'b0) begin n_bad++; $display("FAIL reset_carry: got %b want 0", bus.carry); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_load();
    set_src(8'h00, 8'h00, 8'h33, 8'h00);
    drive(3'd1, 2'd2, 1'b0);
    n_cmp++; if (bus.acc_out !== 8'h33) begin n_bad++; $display("FAIL load_acc: got %h want 33", bus.acc_out); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL load_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.depth_cnt !== 3'd0) begin n_bad++; $display("FAIL load_depth: got %0d want 0", bus.depth_cnt); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", bus.err); end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_pop [4];
    exp_pop[0] = 8'h03; exp_pop[1] = 8'h02; exp_pop[2] = 8'h01; exp_pop[3] = 8'hA0;
    do_reset();
    set_src(8'hA0, 8'h00, 8'h00, 8'h00);
    drive(3'd1, 2'd0, 1'b0);
    set_src(8'h01, 8'h02, 8'h03, 8'h04);
    for (int k = 0; k < 4; k++) drive(3'd2, 2'(k), 1'b0);
    n_cmp++; if (bus.acc_out !== 8'h04) begin n_bad++; $display("FAIL push4_acc: got %h want 04", bus.acc_out); end
    n_cmp++; if (bus.depth_cnt !== 3'd4) begin n_bad++; $display("FAIL push4_depth: got %0d want 4", bus.depth_cnt); end
    n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL push4_full: got %b want 1", bus.full); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL push4_err: got %b want 0", bus.err); end
    drive(3'd2, 2'd0, 1'b0);
    n_cmp++; if (bus.acc_out !== 8'h04) begin n_bad++; $display("FAIL push_full_acc: got %h want 04", bus.acc_out); end
    n_cmp++; if (bus.depth_cnt !== 3'd4) begin n_bad++; $display("FAIL push_full_depth: got %0d want 4", bus.depth_cnt); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL push_full_err: got %b want 1", bus.err); end
    for (int k = 0; k < 4; k++) begin
      drive(3'd3, 2'(k), 1'b0);
      n_cmp++; if (bus.acc_out !== exp_pop[k]) begin n_bad++; $display("FAIL pop%0d_acc: got %h want %h", k, bus.acc_out, exp_pop[k]); end
    end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL pop_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.depth_cnt !== 3'd0) begin n_bad++; $display("FAIL pop_depth: got %0d want 0", bus.depth_cnt); end
    drive(3'd3, 2'd0, 1'b0);
    n_cmp++; if (bus.acc_out !== 8'hA0) begin n_bad++; $display("FAIL pop_under_acc: got %h want a0", bus.acc_out); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL pop_under_err: got %b want 1", bus.err); end
  endtask

  task automatic test_add();
    logic [7:0] exp_acc;
    logic       exp_c;
`ifdef ACC_STACK_ADD_EN
    exp_acc = 8'h10; exp_c = 1'b1;
`else
    exp_acc = 8'hF0; exp_c = 1'b0;
`endif
    do_reset();
    set_src(8'hF0, 8'h20, 8'h00, 8'h00);
    drive(3'd1, 2'd0, 1'b0);
    drive(3'd4, 2'd1, 1'b0);
    n_cmp++; if (bus.acc_out !== exp_acc) begin n_bad++; $display("FAIL add_acc: got %h want %h", bus.acc_out, exp_acc); end
    n_cmp++; if (bus.carry !== exp_c) begin n_bad++; $display("FAIL add_carry: got %b want %b", bus.carry, exp_c); end
    drive(3'd0, 2'd0, 1'b0);
    drive(3'd1, 2'd2, 1'b0);
    n_cmp++; if (bus.carry !== exp_c) begin n_bad++; $display("FAIL carry_hold: got %b want %b", bus.carry, exp_c); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_src(8'h11, 8'h22, 8'h33, 8'h44);
    drive(3'd2, 2'd0, 1'b0);
    drive(3'd2, 2'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.acc_out !== 8'h00) begin n_bad++; $display("FAIL midrst_acc: got %h want 00", bus.acc_out); end
    n_cmp++; if (bus.depth_cnt !== 3'd0) begin n_bad++; $display("FAIL midrst_depth: got %0d want 0", bus.depth_cnt); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL midrst_empty: got %b want 1", bus.empty); end
    bus.op = 3'd2; bus.src_sel = 2'd3;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.op = 3'd0;
    model_reset();
    n_cmp++; if (bus.acc_out !== 8'h00) begin n_bad++; $display("FAIL rst_discard_acc: got %h want 00", bus.acc_out); end
    n_cmp++; if (bus.depth_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_discard_depth: got %0d want 0", bus.depth_cnt); end
    drive(3'd3, 2'd0, 1'b0);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL midrst_pop_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.acc_out !== 8'h00) begin n_bad++; $display("FAIL midrst_pop_acc: got %h want 00", bus.acc_out); end
  endtask

  task automatic test_err_clr();
    do_reset();
    drive(3'd3, 2'd0, 1'b0);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL errclr_set: got %b want 1", bus.err); end
    drive(3'd3, 2'd0, 1'b1);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL errclr_collide: got %b want 1", bus.err); end
    drive(3'd0, 2'd0, 1'b1);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL errclr_clear: got %b want 0", bus.err); end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [1:0] sel;
    logic       clr;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      set_src(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      op  = 3'($urandom_range(0, 7));
      sel = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 7) == 0);
      drive(op, sel, clr);
      n_cmp++; if (bus.acc_out !== m_acc) begin n_bad++; $display("FAIL rnd%0d_acc: got %h want %h", i, bus.acc_out, m_acc); end
      n_cmp++; if (bus.depth_cnt !== 3'(m_stk.size())) begin n_bad++; $display("FAIL rnd%0d_depth: got %0d want %0d", i, bus.depth_cnt, m_stk.size()); end
      n_cmp++; if (bus.full !== (m_stk.size() == int'(DEPTH))) begin n_bad++; $display("FAIL rnd%0d_full: got %b want %b", i, bus.full, m_stk.size() == int'(DEPTH)); end
      n_cmp++; if (bus.empty !== (m_stk.size() == 0)) begin n_bad++; $display("FAIL rnd%0d_empty: got %b want %b", i, bus.empty, m_stk.size() == 0); end
      n_cmp++; if (bus.carry !== m_carry) begin n_bad++; $display("FAIL rnd%0d_carry: got %b want %b", i, bus.carry, m_carry); end
      n_cmp++; if (bus.err !== m_err) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", i, bus.err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_push_pop();
    test_add();
    test_reset_mid();
    test_err_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
